// File: rtl/load_store_unit_pkg.sv
// Shared core types for the load/store unit: memory ops,
// FSM states and access-size decode.
package load_store_unit_pkg;

    typedef logic [4:0] addr_t;

    typedef enum logic [3:0] {
        NULL,
        REGISTER,
        LOAD_BYTE,
        LOAD_BYTE_UNSIGNED,
        LOAD_HALF,
        LOAD_HALF_UNSIGNED,
        LOAD_WORD,
        STORE_BYTE,
        STORE_HALF,
        STORE_WORD,
        LOAD_WORD_UNSIGNED,
        LOAD_DOUBLE,
        STORE_DOUBLE
    } op_t;

    typedef enum logic [1:0] {IDLE, BUS, WAIT, RESP} lsu_state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;

    function automatic logic is_load(op_t op);
        return op inside {LOAD_BYTE, LOAD_BYTE_UNSIGNED, LOAD_HALF,
                          LOAD_HALF_UNSIGNED, LOAD_WORD,
                          LOAD_WORD_UNSIGNED, LOAD_DOUBLE};
    endfunction

    function automatic logic is_store(op_t op);
        return op inside {STORE_BYTE, STORE_HALF, STORE_WORD,
                          STORE_DOUBLE};
    endfunction

    function automatic logic is_signed(op_t op);
        return op inside {LOAD_BYTE, LOAD_HALF, LOAD_WORD,
                          LOAD_DOUBLE};
    endfunction

    function automatic size_t size_of(op_t op);
        size_t sz;
        sz = SZ_B;
        if (op inside {LOAD_HALF, LOAD_HALF_UNSIGNED, STORE_HALF})
            sz = SZ_H;
        if (op inside {LOAD_WORD, LOAD_WORD_UNSIGNED, STORE_WORD})
            sz = SZ_W;
        if (op inside {LOAD_DOUBLE, STORE_DOUBLE})
            sz = SZ_D;
        return sz;
    endfunction

    // True when op is a memory access legal for this XLEN at this offset.
    function automatic logic op_ok(op_t op, logic [2:0] lo, int xlen);
        logic ok;
        ok = is_load(op) || is_store(op);
        if (op inside {LOAD_WORD_UNSIGNED, LOAD_DOUBLE, STORE_DOUBLE}
            && xlen != 64)
            ok = 1'b0;
        unique case (size_of(op))
            SZ_H: if (lo[0] != 1'b0) ok = 1'b0;
            SZ_W: if (lo[1:0] != 2'd0) ok = 1'b0;
            SZ_D: if (lo != 3'd0) ok = 1'b0;
            default: ;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request, memory-bus and response channels of the load/store unit.
// slave is the LSU side, master the pipeline/memory side.
interface load_store_unit_if #(
    parameter int XLEN = 32,
    parameter int AW   = 32
);
    import load_store_unit_pkg::*;

    logic              req_valid;
    logic              req_ready;
    op_t               req_op;
    logic [AW-1:0]     req_addr;
    logic [XLEN-1:0]   req_wdata;
    addr_t             req_rd;
    logic              flush;

    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_strb;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_data;
    addr_t             rsp_rd;
    logic              rsp_fault;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_rd, flush,
        input  mem_ready, mem_rvalid, mem_rdata, rsp_ready,
        output req_ready, mem_valid, mem_we, mem_addr, mem_wdata,
        output mem_strb, rsp_valid, rsp_data, rsp_rd, rsp_fault
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_rd, flush,
        output mem_ready, mem_rvalid, mem_rdata, rsp_ready,
        input  req_ready, mem_valid, mem_we, mem_addr, mem_wdata,
        input  mem_strb, rsp_valid, rsp_data, rsp_rd, rsp_fault
    );

endinterface

// File: rtl/load_store_unit_align.sv
// lsu_align: byte strobes, store-data lane replication and
// load lane extraction with sign/zero extension.
module lsu_align
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB = XLEN / 8,
    localparam int OW = $clog2(NB)
) (
    input  op_t             op,
    input  logic [OW-1:0]   off,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [NB-1:0]   strb,
    output logic [XLEN-1:0] wrep,
    output logic [XLEN-1:0] rext
);

    size_t           sz;
    logic [7:0]      mask;
    logic [XLEN-1:0] sh;
    logic            sgn;
    int              nb;
    int              top;

    always_comb begin
        sz   = size_of(op);
        sgn  = is_signed(op);
        nb   = 1 << int'(sz);
        top  = (8 * nb > XLEN) ? XLEN - 1 : 8 * nb - 1;
        mask = 8'h00;
        wrep = '0;
        rext = '0;
        unique case (sz)
            SZ_B: mask = 8'h01;
            SZ_H: mask = 8'h03;
            SZ_W: mask = 8'h0F;
            SZ_D: mask = 8'hFF;
        endcase
        strb = NB'(mask) << off;
        for (int i = 0; i < NB; i++)
            wrep[8*i +: 8] = wdata[8*(i & (nb - 1)) +: 8];
        sh = rdata >> {off, 3'b000};
        // Bits above the access size take the sign bit or zero.
        for (int i = 0; i < XLEN; i++)
            rext[i] = (i <= top) ? sh[i] : (sgn & sh[top]);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding request, aligned bus accesses,
// misaligned or non-memory ops answered with a fault.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 32
) (
    input logic              clk,
    input logic              reset,
    load_store_unit_if.slave bus
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    lsu_state_t      state, state_n;
    op_t             op_q;
    logic [AW-1:0]   addr_q;
    logic [XLEN-1:0] wdata_q;
    addr_t           rd_q;
    logic [XLEN-1:0] data_q, data_n;
    logic            fault_q, fault_n;
    logic            kill_q, kill_n;
    logic            accept;
    logic [NB-1:0]   strb;
    logic [XLEN-1:0] wrep;
    logic [XLEN-1:0] rext;

    lsu_align #(.XLEN(XLEN)) u_align (
        .op    (op_q),
        .off   (addr_q[OW-1:0]),
        .wdata (wdata_q),
        .rdata (bus.mem_rdata),
        .strb  (strb),
        .wrep  (wrep),
        .rext  (rext)
    );

    assign accept = bus.req_valid && (state == IDLE) && !bus.flush;

    always_comb begin
        state_n = state;
        data_n  = data_q;
        fault_n = fault_q;
        kill_n  = kill_q;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    kill_n = 1'b0;
                    data_n = '0;
                    if (op_ok(bus.req_op, bus.req_addr[2:0], XLEN)) begin
                        state_n = BUS;
                        fault_n = 1'b0;
                    end else begin
                        state_n = RESP;
                        fault_n = 1'b1;
                    end
                end
            end
            BUS: begin
                // A flushed access still finishes on the bus.
                if (bus.flush) kill_n = 1'b1;
                if (bus.mem_ready) begin
                    if (is_store(op_q))
                        state_n = kill_n ? IDLE : RESP;
                    else
                        state_n = WAIT;
                end
            end
            WAIT: begin
                if (bus.flush) kill_n = 1'b1;
                if (bus.mem_rvalid) begin
                    data_n  = rext;
                    state_n = kill_n ? IDLE : RESP;
                end
            end
            RESP: begin
                if (bus.flush || bus.rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= NULL;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            fault_q <= 1'b0;
            kill_q  <= 1'b0;
        end else begin
            state   <= state_n;
            data_q  <= data_n;
            fault_q <= fault_n;
            kill_q  <= kill_n;
            if (accept) begin
                op_q    <= bus.req_op;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                rd_q    <= bus.req_rd;
            end
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.mem_valid = (state == BUS);
    assign bus.mem_we    = (state == BUS) && is_store(op_q);
    assign bus.mem_addr  = {addr_q[AW-1:OW], {OW{1'b0}}};
    assign bus.mem_wdata = wrep;
    assign bus.mem_strb  = (state == BUS) ? strb : '0;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_rd    = rd_q;
    assign bus.rsp_fault = fault_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 and 64 are legal.
REQ-002 SHALL have parameter AW, default 32, byte-address width.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1, req_op in op_t, req_addr in AW, req_wdata in XLEN, req_rd in addr_t.
- req_* is the request channel from the pipeline.
REQ-006 SHALL have port flush  in  1  kills the in-flight request.
REQ-007 SHALL have ports mem_valid out 1, mem_ready in 1, mem_we out 1, mem_addr out AW, mem_wdata out XLEN, mem_strb out XLEN/8.
REQ-008 SHALL have ports mem_rvalid in 1, mem_rdata in XLEN.
REQ-009 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_data out XLEN, rsp_rd out addr_t, rsp_fault out 1.

Function
REQ-010 SHALL implement FSM states IDLE, BUS, WAIT, RESP, with one outstanding request.
REQ-011 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both high; op, addr, wdata and rd are registered on accept.
REQ-012 SHALL on accept go to BUS for a load or store that is aligned; otherwise go to RESP with rsp_fault=1 and make no bus access.
- Misaligned: half with addr[0]!=0; word with addr[1:0]!=0; double with addr[2:0]!=0.
- Non-memory op (NULL, REGISTER) is treated the same as misaligned.
REQ-013 SHALL in BUS drive mem_valid=1 with mem_addr, mem_we, mem_wdata and mem_strb held stable until mem_ready.
- Earliest mem_valid is the cycle after accept.
REQ-014 SHALL drive mem_addr as req_addr with the low log2(XLEN/8) bits cleared.
REQ-015 SHALL drive mem_strb as the access-size mask (1, 3, 0xF or 0xFF) shifted left by the byte offset.
REQ-016 SHALL drive mem_wdata as the low access-size bytes of wdata replicated across all lanes.
REQ-017 SHALL on a store handshake go to RESP with rsp_data=0 and rsp_fault=0.
REQ-018 SHALL on a load handshake go to WAIT, and on mem_rvalid go to RESP.
- Load data is the lane selected by the byte offset, sign- or zero-extended to XLEN according to op.
REQ-019 SHALL ignore mem_rvalid in the handshake cycle itself; rdata arrives no earlier than the following cycle.
REQ-020 SHALL hold rsp_valid=1 and all rsp_* stable in RESP until rsp_ready, then return to IDLE.
- rsp_rd echoes the registered rd.
REQ-021 SHALL meet minimum latencies, counted from accept at t0 with zero-wait memory:
- store: rsp_valid at t2;
- load: rsp_valid at t3;
- fault: rsp_valid at t1.
REQ-022 SHALL when flush is asserted in IDLE or RESP return to IDLE next cycle with rsp_valid=0; flush together with an accept discards that request.
REQ-023 SHALL when flush is asserted in BUS or WAIT never drop mem_valid before mem_ready; the bus transaction completes and its response is suppressed.
REQ-024 SHALL support LOAD_DOUBLE, STORE_DOUBLE and LOAD_WORD_UNSIGNED only when XLEN=64; with XLEN=32 these ops fault.

Reset
REQ-025 SHALL on reset enter IDLE and clear all outputs to 0 (req_ready=1 from the first cycle after reset).
REQ-026 SHALL abandon any transaction on reset, including mid-handshake; mem_valid is 0 in the cycle after reset is sampled.

Structure
REQ-027 SHALL extend op_t in the shared core package with LOAD_WORD_UNSIGNED, LOAD_DOUBLE and STORE_DOUBLE.
- is_load and is_store SHALL cover the new values.
- The lsu state enum and the size-decode function SHALL also live in that package.
REQ-028 SHALL instantiate one sub-module, lsu_align: combinational strobe, write replication and load extract/extend, parametrised by XLEN.

Verification
REQ-029 SHALL cover sign/zero extension: XLEN=32, LOAD_BYTE addr 0x103, rdata 0x80FF1234 -> mem_addr 0x100, rsp_data 0xFFFFFF80; LOAD_BYTE_UNSIGNED same stimulus -> 0x00000080.
REQ-030 SHALL cover store lanes: STORE_HALF addr 0x102, wdata 0x0000ABCD -> mem_addr 0x100, mem_strb 0b1100, mem_wdata 0xABCDABCD, mem_we=1, rsp_valid at t2.
REQ-031 SHALL cover misalignment: LOAD_WORD addr 0x102 -> mem_valid never asserted; rsp_valid at t1 with rsp_fault=1.
REQ-032 SHALL cover backpressure: mem_ready low 3 cycles -> mem_* stable across all 4 cycles; rsp_ready low 2 cycles -> rsp_* stable and req_ready stays 0.
REQ-033 SHALL cover flush in BUS: mem_ready delayed 2 cycles -> handshake still completes, rsp_valid never rises, req_ready returns to 1.
REQ-034 SHALL cover XLEN=64 word lanes: LOAD_WORD addr 0x204, rdata 0x80000001_00000000 -> rsp_data 0xFFFFFFFF80000001; LOAD_WORD_UNSIGNED -> 0x0000000080000001.
